// File: rtl/strobe_catcher.sv
`default_nettype none
// ============================================================================
// Module   : strobe_catcher
// Purpose  : Captures strobe-qualified words into a circular FIFO and presents
//            the head downstream with a valid/ack handshake.
//            Optional zero-latency bypass: STROBE_CATCHER_BYPASS_EN
// Revision : 1.0 - initial release
// ============================================================================
module strobe_catcher #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       anrst,
    input  logic                       strobe,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    input  logic                       ack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int unsigned c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_cw = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);
    localparam logic [c_aw-1:0] c_step = c_aw'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_cw-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_pop;
    logic w_push;
    logic [WIDTH-1:0] w_head;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_full);

`ifdef STROBE_CATCHER_BYPASS_EN
    assign w_bypass = w_empty && strobe;
    assign w_head   = w_empty ? in : mem_q[rd_ptr_q];
`else
    assign w_bypass = 1'b0;
    assign w_head   = mem_q[rd_ptr_q];
`endif

    assign out_valid = anrst && (!w_empty || w_bypass);
    assign out       = out_valid ? w_head : '0;

    assign w_pop  = ack && out_valid;
    // A bypassed word that is acked in the same cycle never enters the buffer.
    assign w_push = strobe && (!w_full || w_pop) && !(w_bypass && w_pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_step;
        end
        if (w_pop && !w_bypass) begin
            rd_ptr_d = rd_ptr_q + c_step;
        end

        unique case ({w_push, w_pop && !w_bypass})
            2'b10:   count_d = count_q + c_one;
            2'b01:   count_d = count_q - c_one;
            default: count_d = count_q;
        endcase

        if (strobe && w_full && !w_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_strobe_catcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_strobe_catcher
// Purpose  : Directed self-checking bench for strobe_catcher (WIDTH=8, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_strobe_catcher;

    logic       clk = 1'b0;
    logic       anrst = 1'b0;
    logic       strobe = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] din = 8'h00;
    wire  [7:0] dout;
    wire        out_valid;
    wire  [2:0] count;
    wire        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    strobe_catcher #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .anrst     (anrst),
        .strobe    (strobe),
        .in        (din),
        .out       (dout),
        .out_valid (out_valid),
        .ack       (ack),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        anrst = 1'b0; strobe = 1'b0; ack = 1'b0; din = 8'h00;
        @(negedge clk);
        anrst = 1'b1;
    endtask

    task automatic push_word(input logic [7:0] w);
        @(negedge clk);
        strobe = 1'b1; din = w; ack = 1'b0;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic test_reset();
        anrst = 1'b0; strobe = 1'b1; din = 8'hA5; ack = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (dout !== 8'h00 || out_valid !== 1'b0 || count !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_hold: out=%h valid=%b count=%0d, expected 00/0/0", dout, out_valid, count);
            end
        end
        @(negedge clk);
        anrst = 1'b1; strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dout !== 8'h00 || out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: out=%h valid=%b count=%0d ovf=%b, expected 00/0/0/0", dout, out_valid, count, overflow);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        strobe = 1'b1; din = 8'h3C; ack = 1'b1;
        #1;
        n_checks++;
`ifdef STROBE_CATCHER_BYPASS_EN
        if (dout !== 8'h3C || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_bypass_same_cycle: out=%h valid=%b, expected 3c/1", dout, out_valid);
        end
`else
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_comb_path: out=%h valid=%b, expected 00/0", dout, out_valid);
        end
`endif
        @(posedge clk); #1;
        strobe = 1'b0; ack = 1'b0;
        #1;
        n_checks++;
`ifdef STROBE_CATCHER_BYPASS_EN
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_bypass_consumed: count=%0d valid=%b, expected 0/0", count, out_valid);
        end
`else
        if (count !== 3'd1 || out_valid !== 1'b1 || dout !== 8'h3C) begin
            n_fail++;
            $display("FAIL single_registered: count=%0d valid=%b out=%h, expected 1/1/3c", count, out_valid, dout);
        end
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_acked: count=%0d valid=%b, expected 0/0", count, out_valid);
        end
`endif
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            strobe = 1'b1; din = 8'(i); ack = 1'b0;
        end
        @(negedge clk);
        strobe = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_full: count=%0d ovf=%b, expected 4/1", count, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dout !== 8'(k + 1) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_read%0d: out=%h valid=%b, expected %h/1", k, dout, out_valid, 8'(k + 1));
            end
            ack = 1'b1;
            @(negedge clk);
            #1;
        end
        ack = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_drained: count=%0d valid=%b ovf=%b, expected 0/0/1", count, out_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_words [4];
        exp_words[0] = 8'hA1; exp_words[1] = 8'hA2; exp_words[2] = 8'hA3; exp_words[3] = 8'hEE;
        do_reset();
        push_word(8'hA0);
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        @(negedge clk);
        strobe = 1'b1; din = 8'hEE; ack = 1'b1;
        #1;
        n_checks++;
        if (dout !== 8'hA0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL fullpp_head: out=%h count=%0d, expected a0/4", dout, count);
        end
        @(negedge clk);
        strobe = 1'b0; ack = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpp_count: count=%0d ovf=%b, expected 4/0", count, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dout !== exp_words[k] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fullpp_read%0d: out=%h valid=%b, expected %h/1", k, dout, out_valid, exp_words[k]);
            end
            ack = 1'b1;
            @(negedge clk);
            #1;
        end
        ack = 1'b0;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got  = 0;
        int maxc = 0;
        do_reset();
        for (int c = 0; c < 80 && got < 10; c++) begin
            @(negedge clk);
            if ((c % 2) == 0 && sent < 10) begin
                strobe = 1'b1; din = 8'(8'h40 + sent); sent++;
            end else begin
                strobe = 1'b0;
            end
            ack = ((c % 2) == 1);
            #1;
            if (int'(count) > maxc) maxc = int'(count);
            if (ack && out_valid) begin
                n_checks++;
                if (dout !== 8'(8'h40 + got)) begin
                    n_fail++;
                    $display("FAIL wrap_word%0d: out=%h, expected %h", got, dout, 8'(8'h40 + got));
                end
                got++;
            end
        end
        @(negedge clk);
        strobe = 1'b0; ack = 1'b0;
        #1;
        n_checks++;
        if (got != 10 || maxc > 4 || overflow !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_summary: got=%0d maxcount=%0d ovf=%b count=%0d, expected 10/<=4/0/0", got, maxc, overflow, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'(8'h91 + i));
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd3 || overflow !== 1'b1 || dout !== 8'h92) begin
            n_fail++;
            $display("FAIL midrst_pre: count=%0d ovf=%b out=%h, expected 3/1/92", count, overflow, dout);
        end
        #1;
        anrst = 1'b0; strobe = 1'b1; din = 8'h77;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async: valid=%b count=%0d ovf=%b out=%h, expected 0/0/0/00", out_valid, count, overflow, dout);
        end
        @(negedge clk);
        anrst = 1'b1; strobe = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_release: valid=%b count=%0d out=%h, expected 0/0/00", out_valid, count, dout);
        end
        push_word(8'h5A);
        #1;
        n_checks++;
        if (dout !== 8'h5A || count !== 3'd1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_fresh: out=%h count=%0d valid=%b, expected 5a/1/1", dout, count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
